// File: rtl/lpm_pkg.sv
// Shared configuration, reorder-buffer entry layout and stride helper for the
// longest-prefix-match lookup engine. Edit the localparams here to resize it.
package lpm_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int STRIDE_W = 8;
  localparam int LEVELS   = 4;
  localparam int TICKETS  = 4;

  localparam int TK_W  = $clog2(TICKETS);
  localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  localparam logic [DATA_W-1:0] ROOT_BASE = '0;
  localparam int                LEAF_BIT  = 0;
  localparam logic [DATA_W-1:0] LEAF_MASK = ~(DATA_W'(1) << LEAF_BIT);
  localparam logic [LVL_W-1:0]  LAST_LVL  = LVL_W'(LEVELS - 1);
  localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
  localparam logic [TK_W:0]     FULL_CNT  = (TK_W + 1)'(TICKETS);
  localparam logic [TK_W:0]     PTR_ONE   = (TK_W + 1)'(1);

  typedef struct packed {
    logic [ADDR_W-1:0] key;
    logic [LVL_W-1:0]  level;
    logic              done;
    logic              miss;
    logic [DATA_W-1:0] result;
  } rob_entry_t;

  // Key bits consumed at trie level lvl, most significant stride first.
  function automatic logic [DATA_W-1:0] chunk(input logic [ADDR_W-1:0] key,
                                              input logic [LVL_W-1:0]  lvl);
    logic [ADDR_W-1:0] w_sh;
    w_sh = key >> (ADDR_W - STRIDE_W - STRIDE_W * int'(lvl));
    return DATA_W'(w_sh[STRIDE_W-1:0]);
  endfunction

endpackage

// File: rtl/lpm_pipe_if.sv
// Handshake bundle around the lookup engine: ingress, result queue and the
// tagged memory request/response channels.
interface lpm_pipe_if;
  import lpm_pkg::*;

  logic              enter__ENA;
  logic [ADDR_W-1:0] enter_x;
  logic              enter__RDY;

  logic              outQ_enq__ENA;
  logic [DATA_W-1:0] outQ_enq_v;
  logic              outQ_enq_miss;
  logic              outQ_enq__RDY;

  logic              mem_req__ENA;
  logic [DATA_W-1:0] mem_req_v;
  logic [TK_W-1:0]   mem_req_tag;
  logic              mem_req__RDY;

  logic              mem_res__ENA;
  logic [DATA_W-1:0] mem_res_v;
  logic [TK_W-1:0]   mem_res_tag;
  logic              mem_res__RDY;

  modport master (
    input  enter__ENA, enter_x,
    output enter__RDY,
    output outQ_enq__ENA, outQ_enq_v, outQ_enq_miss,
    input  outQ_enq__RDY,
    output mem_req__ENA, mem_req_v, mem_req_tag,
    input  mem_req__RDY,
    input  mem_res__ENA, mem_res_v, mem_res_tag,
    output mem_res__RDY
  );

  modport slave (
    output enter__ENA, enter_x,
    input  enter__RDY,
    input  outQ_enq__ENA, outQ_enq_v, outQ_enq_miss,
    output outQ_enq__RDY,
    input  mem_req__ENA, mem_req_v, mem_req_tag,
    output mem_req__RDY,
    output mem_res__ENA, mem_res_v, mem_res_tag,
    input  mem_res__RDY
  );

endinterface

// File: rtl/lpm_rob.sv
// Ticketed reorder buffer: allocates at tail, updates entries by tag as memory
// responses arrive in any order, and presents the head entry for in-order retire.
module lpm_rob
  import lpm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_alloc,
  input  logic [ADDR_W-1:0] i_alloc_key,
  input  logic              i_lvl_we,
  input  logic [TK_W-1:0]   i_lvl_tag,
  input  logic [LVL_W-1:0]  i_lvl,
  input  logic              i_done_we,
  input  logic [TK_W-1:0]   i_done_tag,
  input  logic              i_done_miss,
  input  logic [DATA_W-1:0] i_done_v,
  input  logic              i_retire,
  input  logic [TK_W-1:0]   i_rd_tag,
  output logic [ADDR_W-1:0] o_rd_key,
  output logic [LVL_W-1:0]  o_rd_level,
  output logic [TK_W-1:0]   o_tail,
  output logic              o_head_done,
  output logic              o_head_miss,
  output logic [DATA_W-1:0] o_head_result,
  output logic [TK_W:0]     o_inflight
);

  rob_entry_t        r_rob [TICKETS];
  logic [TK_W:0]     r_head;
  logic [TK_W:0]     r_tail;
  logic [TK_W-1:0]   w_head_idx;
  logic [TK_W-1:0]   w_tail_idx;

  assign w_head_idx = r_head[TK_W-1:0];
  assign w_tail_idx = r_tail[TK_W-1:0];

  // Pointers carry a wrap bit so full (diff == TICKETS) and empty are distinct.
  assign o_inflight    = r_tail - r_head;
  assign o_tail        = w_tail_idx;
  assign o_rd_key      = r_rob[i_rd_tag].key;
  assign o_rd_level    = r_rob[i_rd_tag].level;
  assign o_head_done   = r_rob[w_head_idx].done;
  assign o_head_miss   = r_rob[w_head_idx].miss;
  assign o_head_result = r_rob[w_head_idx].result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      r_head <= '0;
      r_tail <= '0;
      // NOTE: the ROB is a small flop array, not a RAM, so it is reset; a stale done bit would retire garbage.
      for (int i = 0; i < TICKETS; i++) r_rob[i] <= '0;
    end else begin
      if (i_retire) begin
        r_rob[w_head_idx] <= '0;
        r_head            <= r_head + PTR_ONE;
      end
      if (i_alloc) begin
        r_rob[w_tail_idx] <= '{key: i_alloc_key, level: '0, done: 1'b0,
                               miss: 1'b0, result: '0};
        r_tail            <= r_tail + PTR_ONE;
      end
      if (i_lvl_we) r_rob[i_lvl_tag].level <= i_lvl;
      if (i_done_we) begin
        r_rob[i_done_tag].done   <= 1'b1;
        r_rob[i_done_tag].miss   <= i_done_miss;
        r_rob[i_done_tag].result <= i_done_v;
      end
    end
  end

endmodule

// File: rtl/lpm_pipe.sv
// Multi-stride longest-prefix-match engine: classifies memory responses,
// recirculates unfinished lookups ahead of new entries and generates addresses.
module lpm_pipe
  import lpm_pkg::*;
(
  input  logic          CLK,
  input  logic          nRST,
  lpm_pipe_if.master    bus,
  output logic [TK_W:0] inflight
);

  logic [ADDR_W-1:0] w_rd_key;
  logic [LVL_W-1:0]  w_rd_lvl;
  logic [LVL_W-1:0]  w_next_lvl;
  logic [TK_W-1:0]   w_tail;
  logic              w_head_done;
  logic              w_head_miss;
  logic [DATA_W-1:0] w_head_result;
  logic [TK_W:0]     w_inflight;
  logic              w_leaf;
  logic              w_last;
  logic              w_cont;
  logic              w_recirc;
  logic              w_res_fin;
  logic              w_enter;
  logic              w_retire;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves one unassigned and infers a latch.
    bus.mem_req_v   = '0;
    bus.mem_req_tag = '0;
    w_leaf     = bus.mem_res_v[LEAF_BIT];
    w_last     = (w_rd_lvl == LAST_LVL);
    w_cont     = !w_leaf && !w_last;
    w_next_lvl = w_rd_lvl + LVL_ONE;

    // Everything is gated by nRST so the outputs read 0 the moment reset asserts.
    w_recirc  = nRST && bus.mem_res__ENA && w_cont && bus.mem_req__RDY;
    w_res_fin = nRST && bus.mem_res__ENA && !w_cont;
    bus.mem_res__RDY = nRST && (!w_cont || bus.mem_req__RDY);
    bus.enter__RDY   = nRST && (w_inflight != FULL_CNT) && bus.mem_req__RDY
                       && !(bus.mem_res__ENA && w_cont);
    w_enter          = bus.enter__ENA && bus.enter__RDY;
    bus.mem_req__ENA = w_recirc || w_enter;

    if (w_recirc) begin
      bus.mem_req_v   = (bus.mem_res_v & LEAF_MASK) + chunk(w_rd_key, w_next_lvl);
      bus.mem_req_tag = bus.mem_res_tag;
    end else if (w_enter) begin
      bus.mem_req_v   = ROOT_BASE + chunk(bus.enter_x, '0);
      bus.mem_req_tag = w_tail;
    end
  end

  // Retire side is driven purely from registered ROB state.
  assign bus.outQ_enq__ENA  = w_head_done;
  assign bus.outQ_enq_v     = w_head_result;
  assign bus.outQ_enq_miss  = w_head_miss;
  assign w_retire           = w_head_done && bus.outQ_enq__RDY;
  assign inflight           = w_inflight;

  lpm_rob u_rob (
    .clk           (CLK),
    .rst_n         (nRST),
    .i_alloc       (w_enter),
    .i_alloc_key   (bus.enter_x),
    .i_lvl_we      (w_recirc),
    .i_lvl_tag     (bus.mem_res_tag),
    .i_lvl         (w_next_lvl),
    .i_done_we     (w_res_fin),
    .i_done_tag    (bus.mem_res_tag),
    .i_done_miss   (!w_leaf),
    .i_done_v      (bus.mem_res_v),
    .i_retire      (w_retire),
    .i_rd_tag      (bus.mem_res_tag),
    .o_rd_key      (w_rd_key),
    .o_rd_level    (w_rd_lvl),
    .o_tail        (w_tail),
    .o_head_done   (w_head_done),
    .o_head_miss   (w_head_miss),
    .o_head_result (w_head_result),
    .o_inflight    (w_inflight)
  );

endmodule

// File: doc/lpm_pipe.md
Name: lpm_pipe

Overview:
- Parametrised multi-stride longest-prefix-match lookup engine.
- Accepts destination addresses and walks a trie held in an external tagged memory, one stride per memory round-trip.
- Keeps up to TICKETS lookups in flight, recirculating each until a leaf or the depth limit.
- Retires results strictly in entry order through a ticketed reorder buffer. Successor to the single-ticket, fixed 16-bit-stride lookup block; sits between the ingress queue and the output queue.

Parameters:
ADDR_W, 32, lookup key width
DATA_W, 32, memory word / result width; bit 0 = leaf flag
STRIDE_W, 8, key bits consumed per level
LEVELS, 4, maximum trie depth; ADDR_W >= LEVELS*STRIDE_W
TICKETS, 4, maximum outstanding lookups (power of two, >= 2)
ROOT_BASE, 0, memory address of level-0 table
TK_W, $clog2(TICKETS), ticket/tag width (derived)

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
enter__ENA  in  1  new lookup valid
enter$x  in  ADDR_W  lookup key
enter__RDY  out  1  engine can accept
outQ$enq__ENA  out  1  result valid
outQ$enq$v  out  DATA_W  final memory word
outQ$enq$miss  out  1  depth exhausted without leaf
outQ$enq__RDY  in  1  downstream accepts
mem$req__ENA  out  1  memory read request
mem$req$v  out  DATA_W  read address
mem$req$tag  out  TK_W  ticket of request
mem$req__RDY  in  1  memory accepts request
mem$res__ENA  in  1  response valid
mem$res$v  in  DATA_W  response word
mem$res$tag  in  TK_W  ticket of response
mem$res__RDY  out  1  engine accepts response
inflight  out  TK_W+1  occupied ROB entries

Behaviour:
- Reset (async, nRST low): head = tail = 0, all ROB entries invalid, all outputs 0, inflight = 0. Memory side must be reset with the engine; no stale responses are tolerated.
- ROB entry per ticket: key, level (clog2(LEVELS) bits), done, miss, result.
- Stride chunk at level L: key[ADDR_W-1-L*STRIDE_W -: STRIDE_W], zero-extended to DATA_W.
- Request address: ROOT_BASE + chunk0 at entry; (response value with bit0 masked) + chunk(L+1) on recirculation. Addition is mod 2^DATA_W.
- Response classification for tag t at level L:
  - leaf: v[0] = 1
  - continue: v[0] = 0 and L < LEVELS-1
  - miss: v[0] = 0 and L = LEVELS-1
- mem$res__RDY = 1 for leaf/miss; equals mem$req__RDY for continue. This is a combinational path from res data to res ready.
- Recirculation fire (continue && res__ENA && req__RDY):
  - issue mem$req with tag t in the same cycle; store level L+1.
  - recirculation has priority over enter.
- Enter:
  - enter__RDY = (inflight < TICKETS) && mem$req__RDY && !(mem$res__ENA && continue). It does not depend on enter__ENA.
  - On fire: write the ROB slot at tail, issue a request tagged with tail, tail++ (mod TICKETS, wrap bit kept).
- Leaf/miss accept: set done, result = v, miss flag; no memory request.
- Retire:
  - outQ$enq__ENA = done[head], from registered state, so a result written at cycle n retires no earlier than n+1.
  - On outQ$enq__RDY: clear slot, head++.
  - Held stable while __RDY = 0.
- Full: inflight = TICKETS blocks enter even if a retire occurs the same cycle; enter__RDY rises the next cycle.
- Empty: no output; requests only from enter.
- Simultaneous enter-fire, response, and retire in one cycle: all allowed. inflight updates by +1 (enter), -1 (retire), or 0 (both).
- Responses may return in any order; output order is always entry order.
- Memory request latency from enter: 0 cycles (combinational issue). Minimum end-to-end latency: memory latency + 1 per level + 1.

Decomposition:
- Package lpm_pkg: ticket/level widths, ROB entry typedef, leaf-bit constant, chunk-extract function.
- One sub-module: lpm_rob (TICKETS-entry reorder buffer with alloc/write-by-tag/in-order retire and inflight count).
- Top-level holds classification, arbitration and address generation.

Test Plan:
Params 32/32/8/4/4/ROOT_BASE=0.
- Single leaf: enter x=0x0A010203 -> req v=0x0A tag 0; res v=0x1235 tag 0 -> next cycle outQ v=0x1235 miss=0, inflight back to 0.
- Two levels: x=0x0A010203, res 0x0100 tag 0 -> same-cycle req v=0x0101 tag 0; res 0x0077 -> outQ v=0x77.
- Reordering: enter A (tag 0), B (tag 1); leaf for tag 1 first -> no output; leaf for tag 0 -> outQ A then B on consecutive cycles.
- Full/wrap: 4 enters with no responses -> enter__RDY=0, inflight=4; leaf on tag 0 and retire -> enter__RDY=1 next cycle; next enter uses tag 0.
- Miss: x=0x01020304, responses 0x10, 0x20, 0x30, 0x40 (all even) -> requests 0x01, 0x12, 0x23, 0x34; outQ v=0x40 miss=1.
- Priority/backpressure/reset:
  - continue response plus enter__ENA in the same cycle -> recirc request issued, enter__RDY=0.
  - outQ$enq__RDY=0 for 5 cycles -> v held stable.
  - nRST pulsed mid-lookup -> all outputs 0 immediately, inflight=0.
